// File: rtl/uart_pkg.sv
// Shared UART definitions: configuration encodings, receiver state encoding
// and the baud divisor calculation used by both uart_tx and uart_rx.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Ticks per bit the divisor is computed for.
  localparam int OVS_RATE = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  // Clocks per oversampling tick, rounded to nearest: round(clk_hz / (baud * 16)).
  function automatic logic [15:0] divisor(input int clk_hz, input logic [1:0] sel);
    int baud;
    baud = 2400 << sel;
    return 16'((clk_hz + (baud * OVS_RATE) / 2) / (baud * OVS_RATE));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every divisor(CLK_HZ, sel) clocks.
// A reload restarts the count so ticks are phase-aligned to a frame start.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       reload,
  output logic       tick
);

  localparam logic [15:0] DIV_2400  = divisor(CLK_HZ, BAUD_2400);
  localparam logic [15:0] DIV_4800  = divisor(CLK_HZ, BAUD_4800);
  localparam logic [15:0] DIV_9600  = divisor(CLK_HZ, BAUD_9600);
  localparam logic [15:0] DIV_19200 = divisor(CLK_HZ, BAUD_19200);

  logic [15:0] div;
  logic [15:0] cnt;

  // Divisor select from constant table.
  always_comb begin
    div = DIV_2400;
    case (sel)
      BAUD_2400:  div = DIV_2400;
      BAUD_4800:  div = DIV_4800;
      BAUD_9600:  div = DIV_9600;
      BAUD_19200: div = DIV_19200;
      default:    div = DIV_2400;
    endcase
  end

  // Free-running down-counter; tick is registered when the count expires.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (reload) begin
      cnt  <= div - 16'd1;
      tick <= 1'b0;
    end else if (cnt == 16'd0) begin
      cnt  <= div - 16'd1;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - 16'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, glitch-filtered start detection, midpoint
// sampling of 7/8-bit LSB-first frames with optional parity and 1/2 stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int OVS    = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       frame_error
);

  localparam logic [3:0] S_MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVS - 1);

  logic       sync1, sync2, rx_prev;
  logic       fall;
  logic       tick;
  logic       reload;
  logic [1:0] baud_sel;

  state_t     state;
  logic [3:0] s;
  logic [2:0] idx;
  logic       stop_idx;
  logic [7:0] shift;
  logic       perr, ferr;
  logic [1:0] baud_l, par_l;
  logic       stop_l, len_l;
  logic [2:0] last_idx;
  logic       par_en;
  logic       par_x;

  assign fall     = rx_prev & ~sync2;
  assign reload   = (state == IDLE) && fall;
  assign baud_sel = (state == IDLE) ? baud_rate : baud_l;
  assign last_idx = len_l ? 3'd7 : 3'd6;
  assign par_en   = (par_l == PAR_ODD) || (par_l == PAR_EVEN);
  assign par_x    = (^shift) ^ sync2;

  uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock  (clock),
    .rst    (rst),
    .sel    (baud_sel),
    .reload (reload),
    .tick   (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_in;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // Receive state machine with registered outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s            <= '0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      shift        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      baud_l       <= '0;
      par_l        <= '0;
      stop_l       <= 1'b0;
      len_l        <= 1'b0;
      data_out     <= '0;
      rx_done      <= 1'b0;
      rx_active    <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            s      <= '0;
            baud_l <= baud_rate;
            par_l  <= parity_type;
            stop_l <= stop_bits;
            len_l  <= data_length;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_MID) begin
              s <= '0;
              if (!sync2) begin
                state     <= DATA;
                idx       <= '0;
                shift     <= '0;
                perr      <= 1'b0;
                ferr      <= 1'b0;
                rx_active <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_LAST) begin
              s          <= '0;
              shift[idx] <= sync2;
              if (idx == last_idx) begin
                state    <= par_en ? PARITY : STOP;
                stop_idx <= 1'b0;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s == S_LAST) begin
              s     <= '0;
              // Odd mode wants an odd total count of ones over data plus parity.
              perr  <= (par_l == PAR_ODD) ? ~par_x : par_x;
              state <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == S_LAST) begin
              s <= '0;
              if (!sync2) ferr <= 1'b1;
              if (stop_idx == stop_l) state <= DONE;
              else stop_idx <= 1'b1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DONE: begin
          rx_done      <= 1'b1;
          data_out     <= {shift[7] & len_l, shift[6:0]};
          parity_error <= perr;
          frame_error  <= ferr;
          rx_active    <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx. The clock is chosen so every baud
// divisor is exact (1.536 MHz: 40/20/10/5 clocks per tick) to keep runs short.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int  CLK_HZ = 1_536_000;
  localparam real HALF   = 325.521;
  localparam real B9600  = 104167.0;
  localparam real B19200 = 52083.0;
  localparam real B2400  = 416667.0;

  logic       clock = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       frame_error;

  int checks = 0;
  int errors = 0;

  logic [9:0] rec[$];
  int         act_cnt = 0;
  int         act_len = 0;
  bit         act_seen = 0;

  uart_rx #(.CLK_HZ(CLK_HZ), .OVS(16)) dut (
    .clock        (clock),
    .rst          (rst),
    .rx_in        (rx_in),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_out     (data_out),
    .rx_done      (rx_done),
    .rx_active    (rx_active),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  always #(HALF) clock = ~clock;

  // Record each completed frame and the length of the preceding rx_active window.
  always @(negedge clock) begin
    if (!rst) begin
      act_cnt = 0;
    end else if (rx_done) begin
      rec.push_back({frame_error, parity_error, data_out});
      act_len = act_cnt;
      act_cnt = 0;
    end else if (rx_active) begin
      act_cnt++;
      act_seen = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] r;
    chk({tag, " frame_seen"}, 32'(rec.size() > 0), 32'd1);
    if (rec.size() > 0) begin
      r = rec.pop_front();
      chk({tag, " data"}, 32'(r[7:0]), 32'(d));
      chk({tag, " parity_error"}, 32'(r[8]), 32'(pe));
      chk({tag, " frame_error"}, 32'(r[9]), 32'(fe));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit use_par,
                            input logic pbit, input logic [1:0] stops, input int nstop,
                            input real bt);
    rx_in = 1'b0;
    #(bt);
    for (int i = 0; i < nb; i++) begin
      rx_in = d[i];
      #(bt);
    end
    if (use_par) begin
      rx_in = pbit;
      #(bt);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_in = stops[i];
      #(bt);
    end
    rx_in = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    rx_in       = 1'b1;
    baud_rate   = BAUD_9600;
    parity_type = PAR_ODD;
    stop_bits   = 1'b0;
    data_length = 1'b1;

    #2000;
    @(negedge clock);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset rx_done", 32'(rx_done), 32'h0);
    chk("reset rx_active", 32'(rx_active), 32'h0);
    chk("reset parity_error", 32'(parity_error), 32'h0);
    chk("reset frame_error", 32'(frame_error), 32'h0);
    rst = 1'b1;
    #5000;

    // 9600 8O1, 0x74 has four ones so the odd parity bit is 1
    rec.delete();
    send_frame(8'h74, 8, 1, 1'b1, 2'b11, 1, B9600);
    #(B9600);
    expect_frame("t1", 8'h74, 1'b0, 1'b0);
    chk("t1 single_done", 32'(rec.size()), 32'd0);
    chk("t1 active_len", 32'(act_len >= 1520 && act_len <= 1720), 32'd1);

    // Same frame with wrong parity bit, then a clean 0x55 (four ones, parity 1)
    send_frame(8'h74, 8, 1, 1'b0, 2'b11, 1, B9600);
    #(B9600);
    expect_frame("t2", 8'h74, 1'b1, 1'b0);
    @(negedge clock);
    chk("t2 parity_error_held", 32'(parity_error), 32'd1);
    send_frame(8'h55, 8, 1, 1'b1, 2'b11, 1, B9600);
    #(B9600);
    expect_frame("t3", 8'h55, 1'b0, 1'b0);
    @(negedge clock);
    chk("t3 parity_error_cleared", 32'(parity_error), 32'd0);

    // 20 us low pulse is shorter than the ~52 us start-bit midpoint
    rec.delete();
    act_seen = 0;
    rx_in = 1'b0;
    #20000;
    rx_in = 1'b1;
    #(3 * B9600);
    chk("glitch no_done", 32'(rec.size()), 32'd0);
    chk("glitch no_active", 32'(act_seen), 32'd0);

    // Reset during data bit 4 of 0xA3 (four ones, parity 1), held until the line idles
    fork
      send_frame(8'hA3, 8, 1, 1'b1, 2'b11, 1, B9600);
      begin
        #(5.5 * B9600);
        rst = 1'b0;
      end
    join
    #(B9600);
    @(negedge clock);
    chk("midreset no_done", 32'(rec.size()), 32'd0);
    chk("midreset data_out", 32'(data_out), 32'h0);
    chk("midreset rx_active", 32'(rx_active), 32'h0);
    rst = 1'b1;
    #(B9600);
    send_frame(8'h3C, 8, 1, 1'b1, 2'b11, 1, B9600);
    #(B9600);
    expect_frame("t4", 8'h3C, 1'b0, 1'b0);
    chk("t4 single_done", 32'(rec.size()), 32'd0);

    // 19200 7N2: 0x5A as seven bits, then with the second stop bit low
    baud_rate   = BAUD_19200;
    parity_type = PAR_NONE;
    stop_bits   = 1'b1;
    data_length = 1'b0;
    #(B19200);
    send_frame(8'h5A, 7, 0, 1'b0, 2'b11, 2, B19200);
    #(2 * B19200);
    expect_frame("t5", 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 7, 0, 1'b0, 2'b01, 2, B19200);
    #(2 * B19200);
    expect_frame("t6", 8'h5A, 1'b0, 1'b1);
    @(negedge clock);
    chk("t6 frame_error_held", 32'(frame_error), 32'd1);

    // 2400 8N1 back-to-back with +/-2% bit-period skew
    baud_rate   = BAUD_2400;
    stop_bits   = 1'b0;
    data_length = 1'b1;
    #(B2400);
    rec.delete();
    send_frame(8'h00, 8, 0, 1'b0, 2'b11, 1, B2400 * 0.98);
    send_frame(8'hFF, 8, 0, 1'b0, 2'b11, 1, B2400 * 1.02);
    send_frame(8'h81, 8, 0, 1'b0, 2'b11, 1, B2400 * 0.98);
    #(B2400);
    expect_frame("b2b0", 8'h00, 1'b0, 1'b0);
    expect_frame("b2b1", 8'hFF, 1'b0, 1'b0);
    expect_frame("b2b2", 8'h81, 1'b0, 1'b0);
    chk("b2b count", 32'(rec.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
